// File: rtl/rx_pkt_sequencer.sv
// rx_pkt_sequencer: 2-deep packet FIFO feeding a LOAD/FIRE/SETTLE pulse
// sequencer that presents parsed fields and a one-cycle en_MNI to myNodeInfo.
//
// Ports:
//   clk, nrst                 clock, async active-low reset
//   in_valid / in_ready       packet handshake (push on both high)
//   in_pktType .. in_eThreshold   parsed fields of the offered packet
//   fPktType .. e_threshold   registered fields (change only on pop)
//   en_MNI                    one-cycle enable pulse per valid packet
//   busy                      packet queued or in flight
//   drop_count                reserved-type drops, saturating
//                             (only with RXSEQ_DROPCNT_EN defined)
// Parameter SETTLE_CYC (1..15): idle cycles held after each en_MNI.
module rx_pkt_sequencer #(
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_pktType,
  input  logic [15:0] in_energy,
  input  logic [15:0] in_destID,
  input  logic [15:0] in_hops,
  input  logic [15:0] in_timeslot,
  input  logic [15:0] in_eThreshold,
  output logic [2:0]  fPktType,
  output logic [15:0] energy,
  output logic [15:0] destinationID,
  output logic [15:0] hops,
  output logic [15:0] timeslot,
  output logic [15:0] e_threshold,
  output logic        en_MNI,
  output logic        busy
`ifdef RXSEQ_DROPCNT_EN
  ,
  output logic [7:0]  drop_count
`endif
);

  typedef struct packed {
    logic [2:0]  t;
    logic [15:0] e;
    logic [15:0] d;
    logic [15:0] h;
    logic [15:0] s;
    logic [15:0] th;
  } pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIRE,
    SETTLE
  } state_t;

  state_t      state;
  state_t      state_nx;
  pkt_t        mem [2];
  pkt_t        in_pkt;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  cnt;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        rsv;
  logic [3:0]  settle_cnt;

  assign in_pkt = {in_pktType, in_energy, in_destID,
                   in_hops, in_timeslot, in_eThreshold};

  assign full     = (cnt == 2'd2);
  assign empty    = (cnt == 2'd0);
  // No bypass: a full FIFO refuses input even while it pops.
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign pop      = (state == IDLE) & ~empty;
  assign busy     = (state != IDLE) | ~empty;

  // Types 011, 110 and 111 are reserved and dropped silently.
  assign rsv = (fPktType == 3'b011) |
               (fPktType == 3'b110) |
               (fPktType == 3'b111);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_pkt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fPktType      <= 3'b111;
      energy        <= '0;
      destinationID <= '0;
      hops          <= '0;
      timeslot      <= '0;
      e_threshold   <= '0;
    end else if (pop) begin
      fPktType      <= mem[rd_ptr].t;
      energy        <= mem[rd_ptr].e;
      destinationID <= mem[rd_ptr].d;
      hops          <= mem[rd_ptr].h;
      timeslot      <= mem[rd_ptr].s;
      e_threshold   <= mem[rd_ptr].th;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
    end else begin
      state <= state_nx;
      if (state == FIRE)
        settle_cnt <= 4'(SETTLE_CYC);
      else if (state == SETTLE && settle_cnt != 4'd0)
        settle_cnt <= settle_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nx = state;
    en_MNI   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) state_nx = LOAD;
      end
      LOAD: begin
        state_nx = rsv ? IDLE : FIRE;
      end
      FIRE: begin
        en_MNI   = 1'b1;
        state_nx = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt <= 4'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef RXSEQ_DROPCNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      drop_count <= 8'd0;
    else if (state == LOAD && rsv && drop_count != 8'hFF)
      drop_count <= drop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_rx_pkt_sequencer.sv
// tb_rx_pkt_sequencer: directed bench with a pulse scoreboard for
// rx_pkt_sequencer (SETTLE_CYC=3).
module tb_rx_pkt_sequencer;

  typedef struct packed {
    logic [2:0]  t;
    logic [15:0] e;
    logic [15:0] d;
    logic [15:0] h;
    logic [15:0] s;
    logic [15:0] th;
  } pkt_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_pktType = '0;
  logic [15:0] in_energy = '0;
  logic [15:0] in_destID = '0;
  logic [15:0] in_hops = '0;
  logic [15:0] in_timeslot = '0;
  logic [15:0] in_eThreshold = '0;
  logic [2:0]  fPktType;
  logic [15:0] energy;
  logic [15:0] destinationID;
  logic [15:0] hops;
  logic [15:0] timeslot;
  logic [15:0] e_threshold;
  logic        en_MNI;
  logic        busy;
`ifdef RXSEQ_DROPCNT_EN
  logic [7:0]  drop_count;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   exp_drop = 0;
  int   c0;
  logic acc;
  pkt_t sb[$];
  int   pulses[$];

  rx_pkt_sequencer #(.SETTLE_CYC(3)) dut (
    .clk(clk),
    .nrst(nrst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pktType(in_pktType),
    .in_energy(in_energy),
    .in_destID(in_destID),
    .in_hops(in_hops),
    .in_timeslot(in_timeslot),
    .in_eThreshold(in_eThreshold),
    .fPktType(fPktType),
    .energy(energy),
    .destinationID(destinationID),
    .hops(hops),
    .timeslot(timeslot),
    .e_threshold(e_threshold),
    .en_MNI(en_MNI),
    .busy(busy)
`ifdef RXSEQ_DROPCNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rsv(input logic [2:0] t);
    return t == 3'b011 || t == 3'b110 || t == 3'b111;
  endfunction

  function automatic pkt_t mk(input logic [2:0] t, input logic [15:0] e,
                              input logic [15:0] d, input logic [15:0] h,
                              input logic [15:0] s, input logic [15:0] th);
    pkt_t p;
    p.t = t; p.e = e; p.d = d; p.h = h; p.s = s; p.th = th;
    return p;
  endfunction

  task automatic put(input pkt_t p);
    in_valid      = 1'b1;
    in_pktType    = p.t;
    in_energy     = p.e;
    in_destID     = p.d;
    in_hops       = p.h;
    in_timeslot   = p.s;
    in_eThreshold = p.th;
  endtask

  // One clock: model the push at the edge, then check any en_MNI
  // pulse against the oldest expected packet.
  task automatic tick(output logic a);
    pkt_t p;
    pkt_t e;
    a = nrst & in_valid & in_ready;
    p = {in_pktType, in_energy, in_destID,
         in_hops, in_timeslot, in_eThreshold};
    @(posedge clk);
    cyc++;
    if (a) begin
      if (rsv(p.t)) begin
        if (exp_drop < 255) exp_drop++;
      end else begin
        sb.push_back(p);
      end
    end
    #1;
    if (en_MNI === 1'b1) begin
      pulses.push_back(cyc);
      chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pulse_type", 32'(fPktType), 32'(e.t));
        chk("pulse_energy", 32'(energy), 32'(e.e));
        chk("pulse_dest", 32'(destinationID), 32'(e.d));
        chk("pulse_hops", 32'(hops), 32'(e.h));
        chk("pulse_tslot", 32'(timeslot), 32'(e.s));
        chk("pulse_ethr", 32'(e_threshold), 32'(e.th));
      end
    end
  endtask

  task automatic tk();
    logic a;
    tick(a);
  endtask

  task automatic chk_drop(input string tag);
`ifdef RXSEQ_DROPCNT_EN
    chk(tag, 32'(drop_count), 32'(exp_drop));
`else
    chk(tag, 32'(exp_drop > 255), 32'd0);
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_en_MNI"}, 32'(en_MNI), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_type"}, 32'(fPktType), 32'd7);
    chk({tag, "_energy"}, 32'(energy), 32'd0);
    chk({tag, "_dest"}, 32'(destinationID), 32'd0);
    chk({tag, "_hops"}, 32'(hops), 32'd0);
    chk({tag, "_tslot"}, 32'(timeslot), 32'd0);
    chk({tag, "_ethr"}, 32'(e_threshold), 32'd0);
    chk_drop({tag, "_drop"});
  endtask

  initial begin
    repeat (3) tk();
    chk_reset("rst");
    nrst = 1'b1;
    tk();

    // Single HB packet: fields one edge after push, pulse one later.
    put(mk(3'b000, 16'h8000, 16'h0005, 16'd1, 16'h0011, 16'h3333));
    tk();
    in_valid = 1'b0;
    c0 = cyc;
    chk("t1_busy_queued", 32'(busy), 32'd1);
    chk("t1_type_held", 32'(fPktType), 32'd7);
    tk();
    chk("t1_type", 32'(fPktType), 32'd0);
    chk("t1_hops", 32'(hops), 32'd1);
    chk("t1_energy", 32'(energy), 32'h8000);
    chk("t1_ethr", 32'(e_threshold), 32'h3333);
    chk("t1_load_en", 32'(en_MNI), 32'd0);
    tk();
    chk("t1_fire_en", 32'(en_MNI), 32'd1);
    tk();
    chk("t1_settle_en", 32'(en_MNI), 32'd0);
    tk();
    tk();
    chk("t1_busy_settle", 32'(busy), 32'd1);
    tk();
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_hops_hold", 32'(hops), 32'd1);
    chk("t1_npulse", 32'(pulses.size()), 32'd1);
    if (pulses.size() == 1)
      chk("t1_pulse_lat", 32'(pulses[0] - c0), 32'd2);
    pulses.delete();

    // Back-to-back CHE and INV: pulses 6 cycles apart.
    put(mk(3'b001, 16'h0100, 16'h000C, 16'd2, 16'd0, 16'd0));
    tk();
    put(mk(3'b010, 16'h0200, 16'd32, 16'd4, 16'd7, 16'h1234));
    tk();
    in_valid = 1'b0;
    repeat (16) tk();
    chk("t2_npulse", 32'(pulses.size()), 32'd2);
    if (pulses.size() == 2)
      chk("t2_gap", 32'(pulses[1] - pulses[0]), 32'd6);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    pulses.delete();

    // Held in_valid: FIFO fills, no bypass on the pop cycle.
    put(mk(3'b101, 16'h1111, 16'd1, 16'd1, 16'd1, 16'd1));
    tk();
    chk("t3_rdy_a", 32'(in_ready), 32'd1);
    put(mk(3'b100, 16'h2222, 16'd2, 16'd2, 16'd2, 16'd2));
    tk();
    chk("t3_rdy_b", 32'(in_ready), 32'd1);
    put(mk(3'b000, 16'h3333, 16'd3, 16'd3, 16'd3, 16'd3));
    tk();
    chk("t3_full", 32'(in_ready), 32'd0);
    put(mk(3'b001, 16'h4444, 16'd4, 16'd4, 16'd4, 16'd4));
    for (int i = 0; i < 4; i++) begin
      tk();
      chk("t3_full_hold", 32'(in_ready), 32'd0);
    end
    tk();
    chk("t3_rdy_after_pop", 32'(in_ready), 32'd1);
    tk();
    in_valid = 1'b0;
    chk("t3_full_again", 32'(in_ready), 32'd0);
    repeat (30) tk();
    chk("t3_npulse", 32'(pulses.size()), 32'd4);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    pulses.delete();

    // Reserved 111 dropped, then DATA fires.
    put(mk(3'b111, 16'hDEAD, 16'd9, 16'd9, 16'd9, 16'd9));
    tk();
    c0 = cyc;
    put(mk(3'b101, 16'h0050, 16'd14, 16'd3, 16'd6, 16'h0040));
    tk();
    in_valid = 1'b0;
    repeat (12) tk();
    chk("t4_npulse", 32'(pulses.size()), 32'd1);
    if (pulses.size() == 1)
      chk("t4_pulse_at", 32'(pulses[0] - c0), 32'd4);
    chk_drop("t4_drop");
    chk("t4_dest", 32'(destinationID), 32'd14);
    pulses.delete();

    // Reset in SETTLE with a second packet queued.
    put(mk(3'b000, 16'h0A0A, 16'd21, 16'd5, 16'd1, 16'd2));
    tk();
    put(mk(3'b100, 16'h0B0B, 16'd22, 16'd6, 16'd3, 16'd4));
    tk();
    in_valid = 1'b0;
    tk();
    tk();
    chk("t5_in_settle", 32'(busy), 32'd1);
    #1;
    nrst = 1'b0;
    sb.delete();
    exp_drop = 0;
    #1;
    chk_reset("t5_rst");
    repeat (2) tk();
    nrst = 1'b1;
    repeat (20) tk();
    chk("t5_npulse", 32'(pulses.size()), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    pulses.delete();

    // 256 reserved packets: drop counter saturates, no pulses.
    for (int i = 0; i < 256; i++) begin
      logic [2:0] t;
      t = (i % 3 == 0) ? 3'b011 : ((i % 3 == 1) ? 3'b110 : 3'b111);
      put(mk(t, 16'(i), 16'(i), 16'd0, 16'd0, 16'd0));
      acc = 1'b0;
      for (int k = 0; k < 10 && !acc; k++) tick(acc);
      chk("t6_accept", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    repeat (10) tk();
    chk("t6_npulse", 32'(pulses.size()), 32'd0);
    chk_drop("t6_drop_sat");
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_type_last", 32'(fPktType), 32'd0 + 32'(3'b011));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_pkt_sequencer.md
RX_PKT_SEQUENCER -- requirements
Module: rx_pkt_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 3, meaning idle cycles held after each en_MNI pulse (legal 1..15).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  parsed packet offered.
REQ-005 SHALL have port in_ready  output  1  sequencer accepts packet this cycle.
REQ-006 SHALL have ports in_pktType[2:0], in_energy[15:0], in_destID[15:0], in_hops[15:0], in_timeslot[15:0], in_eThreshold[15:0], all inputs, parsed packet fields.
REQ-007 SHALL have ports fPktType[2:0], energy[15:0], destinationID[15:0], hops[15:0], timeslot[15:0], e_threshold[15:0], all outputs, registered fields driven to myNodeInfo.
REQ-008 SHALL have port en_MNI  output  1  one-cycle enable pulse to myNodeInfo.
REQ-009 SHALL have port busy  output  1  packet queued or in progress.

Function
REQ-010 SHALL buffer packets in a 2-entry FIFO (all six fields per entry); in_ready = FIFO not full; push on in_valid & in_ready.
REQ-011 SHALL not bypass: when full, in_ready stays 0 even in a pop cycle.
REQ-012 SHALL implement FSM IDLE, LOAD, FIRE, SETTLE.
REQ-013 IDLE: if FIFO non-empty, pop head into output field registers and go LOAD on the same edge; else stay.
REQ-014 LOAD: fields stable, en_MNI=0; valid types (000 HB, 001 CHE, 010 INV, 100 CHTimeslot, 101 DATA) go FIRE; reserved types (011, 110, 111) go IDLE and are dropped without en_MNI.
REQ-015 FIRE: en_MNI=1 for exactly this cycle; go SETTLE with counter loaded to SETTLE_CYC.
REQ-016 SETTLE: en_MNI=0, fields held, counter decrements each cycle; at count 1 go IDLE.
REQ-017 Valid packet period SHALL be SETTLE_CYC+3 cycles (IDLE, LOAD, FIRE, SETTLE_CYC); dropped packet period 2 cycles.
REQ-018 Output fields SHALL change only on pop; they hold the last packet's values while IDLE.
REQ-019 busy SHALL be 1 when state != IDLE or FIFO non-empty.
REQ-020 FIFO pointers SHALL wrap modulo 2; push and pop in same cycle keep occupancy unchanged.

Reset
REQ-021 nrst low SHALL immediately force state IDLE, FIFO empty, in_ready=1, en_MNI=0, busy=0, fPktType=3'b111, all 16-bit field outputs 0, settle counter 0.
REQ-022 Reset asserted mid-packet SHALL discard queued and in-flight packets; no en_MNI after release until a new push.

Configuration
REQ-023 Macro RXSEQ_DROPCNT_EN defined: SHALL add output drop_count[7:0], reset 0, incremented on each LOAD of a reserved type, saturating at 255.
REQ-024 Macro RXSEQ_DROPCNT_EN undefined: port drop_count and its logic SHALL be absent; drop behaviour otherwise identical.

Verification
REQ-025 Reset release, push HB (type 000, hops=1, energy=16'h8000, eThreshold=16'h3333) -> fields valid next edge, en_MNI high exactly 1 cycle one cycle later, busy low after 6 cycles total (SETTLE_CYC=3).
REQ-026 Push CHE destID=16'h000C then INV destID=32 back-to-back -> two en_MNI pulses exactly 6 cycles apart, destinationID 16'h000C at first pulse, 32 at second.
REQ-027 Hold in_valid with 3 packets while sequencing -> in_ready drops after 2 accepted, reasserts after first pop; all 3 fire in order.
REQ-028 Push type 111 then DATA (101, destID=14, hops=3) -> no pulse for 111, drop_count=1 (macro defined), DATA pulse 2 cycles after 111 LOAD +1.
REQ-029 Assert nrst during SETTLE with one packet queued -> outputs at reset values at once, no further en_MNI after release.
REQ-030 Push 256 reserved-type packets (macro defined) -> drop_count saturates at 255, en_MNI never asserted.
